// File: rtl/bist_pkg.sv
// bist_pkg: FSM state type and width-generic LFSR/MISR next-state functions.
package bist_pkg;
    typedef enum logic [1:0] {IDLE, INIT, RUN, DONE} state_t;
    localparam int MAX_W = 64;
    function automatic logic [MAX_W-1:0] wmask(input int w);
        return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction
    function automatic logic [MAX_W-1:0] lfsr_next(input logic [MAX_W-1:0] v, input logic [MAX_W-1:0] taps, input int w);
        return ((v << 1) | MAX_W'(^(v & taps))) & wmask(w);
    endfunction
    function automatic logic [MAX_W-1:0] misr_next(input logic [MAX_W-1:0] v, input logic [MAX_W-1:0] poly, input logic [MAX_W-1:0] din, input int w);
        return ((v << 1) ^ ((|(v & (MAX_W'(1) << (w - 1)))) ? poly : '0) ^ din) & wmask(w);
    endfunction
endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: loadable shift register; Fibonacci LFSR or Galois MISR feedback selected by MISR_MODE.
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int W = 4,
    parameter logic [W-1:0] MASK = '0,
    parameter bit MISR_MODE = 1'b0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] pi,
    output logic [W-1:0] q
);
    logic [W-1:0] nx;
    // pi is the parallel-input XOR; tie it to zero for a plain pattern generator
    always_comb nx = MISR_MODE ? W'(misr_next(MAX_W'(q), MAX_W'(MASK), MAX_W'(pi), W))
                               : W'(lfsr_next(MAX_W'(q), MAX_W'(MASK), W)) ^ pi;
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= RST_VAL;
        else if (load) q <= load_val;
        else if (en) q <= nx;
endmodule

// File: rtl/seq_bist_ctrl.sv
// seq_bist_ctrl: BIST controller driving LFSR patterns into a sequential DUT and
// compacting its outputs into a MISR signature checked against a golden value.
module seq_bist_ctrl
    import bist_pkg::*;
#(
    parameter int IN_W = 4,
    parameter int OUT_W = 1,
    parameter int LFSR_W = 4,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 4'b1100,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 4'b0001,
    parameter int PAT_CNT = 16,
    parameter int INIT_CYC = 1,
    parameter int MISR_W = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [IN_W-1:0]   dut_pi,
    input  logic [OUT_W-1:0]  dut_po,
    output logic              dut_init,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);
    localparam int PW = $clog2(PAT_CNT + 1);
    localparam int IW = $clog2(INIT_CYC + 1);
    localparam logic [LFSR_W-1:0] SEED = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    state_t state, nxt;
    logic [PW-1:0] pcnt;
    logic [IW-1:0] icnt;
    logic [LFSR_W-1:0] lfsr_q, pat_d;
    logic go, init_end, run_end, run;

    bist_lfsr #(.W(LFSR_W), .MASK(LFSR_TAPS), .MISR_MODE(1'b0), .RST_VAL(SEED)) u_lfsr (
        .clk(clock), .rst(reset), .load(go), .en(run), .load_val(SEED), .pi('0), .q(lfsr_q)
    );

    bist_lfsr #(.W(MISR_W), .MASK(MISR_POLY), .MISR_MODE(1'b1), .RST_VAL('0)) u_misr (
        .clk(clock), .rst(reset), .load(go), .en(run), .load_val('0), .pi(MISR_W'(dut_po)), .q(signature)
    );

    always_comb begin
        run = state == RUN;
        go = (state == IDLE || state == DONE) && start;
        init_end = state == INIT && icnt == IW'(INIT_CYC - 1);
        run_end = run && pcnt == PW'(PAT_CNT - 1);
        nxt = go ? INIT : init_end ? RUN : run_end ? DONE : state;
        // dut_pi is registered, so it is loaded with the pattern the LFSR holds after this edge
        pat_d = run ? LFSR_W'(lfsr_next(MAX_W'(lfsr_q), MAX_W'(LFSR_TAPS), LFSR_W)) : lfsr_q;
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= IDLE;
            pcnt <= '0;
            icnt <= '0;
            dut_pi <= '0;
            dut_init <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            state <= nxt;
            icnt <= go ? '0 : (state == INIT) ? icnt + 1'b1 : icnt;
            pcnt <= go ? '0 : run ? pcnt + 1'b1 : pcnt;
            dut_pi <= (nxt == RUN) ? pat_d[IN_W-1:0] : '0;
            dut_init <= nxt == INIT;
            // busy spans the cycle in which the final signature settles before done/pass register
            busy <= nxt == INIT || nxt == RUN || run;
            done <= state == DONE && nxt == DONE;
            pass <= state == DONE && nxt == DONE && signature == GOLDEN_SIG;
        end
endmodule

// File: tb/tb_seq_bist_ctrl.sv
// tb_seq_bist_ctrl: randomized scoreboard bench with a behavioural pattern/signature model.
module tb_seq_bist_ctrl;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, start2 = 1'b0;
    logic [3:0] dut_pi, dut_pi2;
    logic dut_po, dut_init, busy, done, pass;
    logic dut_init2, busy2, done2, pass2;
    logic [15:0] signature, signature2;
    int mode = 0;
    logic [3:0] key = '0;
    int checks = 0, errors = 0, ncyc = 0;

    typedef struct {logic [15:0] sig; logic pass; int cyc;} res_t;
    logic [3:0] q_pat[$];
    res_t q_res[$];
    int init_len = 0, pat_left = 0;
    logic prev_init = 1'b0, prev_done = 1'b0;

    // stand-in DUT: outputs settle combinationally from the applied pattern
    assign dut_po = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ^(dut_pi & key);

    always #5 clk = ~clk;

    seq_bist_ctrl u_dut (
        .clock(clk), .reset(reset), .start(start), .dut_pi(dut_pi), .dut_po(dut_po),
        .dut_init(dut_init), .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    seq_bist_ctrl #(.PAT_CNT(1), .INIT_CYC(3)) u_dut2 (
        .clock(clk), .reset(reset), .start(start2), .dut_pi(dut_pi2), .dut_po(1'b1),
        .dut_init(dut_init2), .busy(busy2), .done(done2), .pass(pass2), .signature(signature2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // issue a start and push the expected pattern stream and result for that run
    task automatic issue_run(input int md, input logic [3:0] k);
        logic [3:0] l = 4'b0001;
        logic [15:0] s = '0;
        logic po;
        int m;
        mode = md;
        key = k;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        m = ncyc;
        for (int i = 0; i < 16; i++) begin
            q_pat.push_back(l);
            po = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 : ^(l & k);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, po};
            l = {l[2:0], l[3] ^ l[2]};
        end
        q_res.push_back('{s, s == 16'h0000, m + 19});
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    always @(negedge clk) begin : mon
        logic [3:0] e;
        res_t r;
        ncyc++;
        if (reset) begin
            q_pat.delete();
            q_res.delete();
            init_len = 0;
            pat_left = 0;
            prev_init = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (dut_init) init_len++;
            else if (prev_init) begin
                chk("init_len", init_len, 1);
                init_len = 0;
                pat_left = 16;
            end
            if (pat_left > 0 && !dut_init) begin
                if (q_pat.size() == 0) chk("pat_unexpected", 1, 0);
                else begin
                    e = q_pat.pop_front();
                    chk("dut_pi", dut_pi, e);
                    chk("busy_run", busy, 1);
                end
                pat_left--;
            end
            if (done && !prev_done) begin
                if (q_res.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    r = q_res.pop_front();
                    chk("signature", signature, r.sig);
                    chk("pass", pass, r.pass);
                    chk("done_cycle", ncyc, r.cyc);
                    chk("busy_done", busy, 0);
                end
            end
            prev_init = dut_init;
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_dut_pi", dut_pi, 0);
        chk("rst_dut_init", dut_init, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_signature", signature, 0);
        reset = 1'b0;
        issue_run(0, 4'h0);
        wait_done();
        issue_run(1, 4'h0);
        wait_done();
        issue_run(2, 4'($urandom_range(1, 15)));
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        issue_run(2, key);
        wait_done();
        issue_run(2, key);
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_dut_pi", dut_pi, 0);
        chk("abort_dut_init", dut_init, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_pass", pass, 0);
        chk("abort_signature", signature, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue_run(2, key);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            issue_run(int'($urandom_range(0, 2)), 4'($urandom));
            wait_done();
        end
        repeat (3) @(negedge clk);
        chk("pat_queue_empty", q_pat.size(), 0);
        chk("res_queue_empty", q_res.size(), 0);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        for (int s = 1; s <= 6; s++) begin
            @(negedge clk);
            chk("short_dut_init", dut_init2, s <= 3);
            chk("short_dut_pi", dut_pi2, (s == 4) ? 1 : 0);
            chk("short_done", done2, s == 6);
        end
        chk("short_signature", signature2, 16'h0001);
        chk("short_pass", pass2, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
